// File: rtl/mod_reduce_seq.sv
// Sequential X mod M reducer: restoring shift-subtract, one dividend bit per cycle.
// Optional quotient output out_q is enabled by defining MOD_REDUCE_QUOT_EN.
module mod_reduce_seq #(
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*W-1:0] in_x,
   input  logic [W-1:0]   in_m,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_r,
   output logic           out_err
`ifdef MOD_REDUCE_QUOT_EN
   ,
   output logic [2*W-1:0] out_q
`endif
);

   localparam int CW = $clog2(2*W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_reg;
   logic [2*W-1:0] x_reg;
   logic [W-1:0]   m_reg;
   logic [W:0]     r_reg;
   logic [CW-1:0]  count_reg;

   logic [W:0]     r_shift;
   logic [W:0]     r_next;
   logic           sub_bit;

   // One restoring step; R stays below M, so the shift cannot overflow W+1 bits.
   always_comb begin
      r_shift = (r_reg << 1) | {{W{1'b0}}, x_reg[count_reg]};
      sub_bit = (r_shift >= {1'b0, m_reg});
      r_next  = sub_bit ? (r_shift - {1'b0, m_reg}) : r_shift;
   end

`ifdef MOD_REDUCE_QUOT_EN
   logic [2*W-1:0] q_reg;
   logic [2*W-1:0] q_next;

   always_comb begin
      q_next = {q_reg[2*W-2:0], sub_bit};
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         x_reg     <= '0;
         m_reg     <= '0;
         r_reg     <= '0;
         count_reg <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_r     <= '0;
         out_err   <= 1'b0;
`ifdef MOD_REDUCE_QUOT_EN
         q_reg     <= '0;
         out_q     <= '0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid && in_ready) begin
                  x_reg     <= in_x;
                  m_reg     <= in_m;
                  r_reg     <= '0;
                  count_reg <= CW'(2*W-1);
                  in_ready  <= 1'b0;
                  out_r     <= '0;
                  out_err   <= (in_m == '0);
`ifdef MOD_REDUCE_QUOT_EN
                  q_reg     <= '0;
                  out_q     <= '0;
`endif
                  state_reg <= (in_m == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               r_reg     <= r_next;
               count_reg <= count_reg - CW'(1);
`ifdef MOD_REDUCE_QUOT_EN
               q_reg     <= q_next;
`endif
               if (count_reg == '0) begin
                  out_valid <= 1'b1;
                  out_r     <= r_next[W-1:0];
`ifdef MOD_REDUCE_QUOT_EN
                  out_q     <= q_next;
`endif
                  state_reg <= DONE;
               end
            end
            DONE: begin
               // The divide-by-zero path enters here with out_valid still low.
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_reg <= IDLE;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Randomized self-checking bench for mod_reduce_seq against an arithmetic % and / model.
// Quotient checks are compiled in when MOD_REDUCE_QUOT_EN is defined.
module tb_mod_reduce_seq;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [2*W-1:0] in_x = '0;
   logic [W-1:0]   in_m = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [W-1:0]   out_r;
   logic           out_err;
`ifdef MOD_REDUCE_QUOT_EN
   logic [2*W-1:0] out_q;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mod_reduce_seq #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_m      (in_m),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .out_err   (out_err)
`ifdef MOD_REDUCE_QUOT_EN
      ,
      .out_q     (out_q)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One complete transaction: accept, wait for result, optional back-pressure, handshake.
   task automatic run_op(input logic [2*W-1:0] x, input logic [W-1:0] m, input int hold);
      logic [63:0] exp_r, exp_q;
      logic        exp_err;
      int          lat, exp_lat, n;
      exp_err = (m == '0);
      exp_r   = exp_err ? 64'd0 : (64'(x) % 64'(m));
      exp_q   = exp_err ? 64'd0 : (64'(x) / 64'(m));
      exp_lat = exp_err ? 1 : 2*W;

      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_idle", 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      in_x      = x;
      in_m      = m;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_x     = {$urandom, $urandom};
      in_m     = W'($urandom);

      lat = 0;
      while (lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         in_x = {$urandom, $urandom};
         in_m = W'($urandom);
         if (out_valid) break;
      end
      check("latency", 64'(lat), 64'(exp_lat));
      check("out_r", 64'(out_r), exp_r);
      check("out_err", 64'(out_err), 64'(exp_err));
`ifdef MOD_REDUCE_QUOT_EN
      check("out_q", 64'(out_q), exp_q);
`endif

      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_x     = {$urandom, $urandom};
         in_m     = W'($urandom);
         @(posedge clk);
         @(negedge clk);
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_ready", 64'(in_ready), 64'd0);
         check("hold_r", 64'(out_r), exp_r);
         check("hold_err", 64'(out_err), 64'(exp_err));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("post_hs_valid", 64'(out_valid), 64'd0);
      check("post_hs_ready", 64'(in_ready), 64'd1);
      $display("op x=0x%0h m=0x%0h hold=%0d -> r=0x%0h err=%0d lat=%0d", x, m, hold, out_r, out_err, lat);
   endtask

   initial begin
      logic [2*W-1:0] rx;
      logic [W-1:0]   rm;

      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_r", 64'(out_r), 64'd0);
      check("rst_out_err", 64'(out_err), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(32'd1000, 16'd7, 0);
      run_op(32'hFFFF_FFFF, 16'hFFFF, 0);
      run_op(32'd5, 16'd9, 0);
      run_op(32'h1234_5678, 16'hFFF1, 0);
      run_op(32'hDEAD, 16'd0, 0);
      run_op(32'd10, 16'd3, 0);
      run_op(32'hABCD_1234, 16'd1, 0);
      run_op(32'd0, 16'h1234, 0);
      run_op(32'h8765_4321, 16'h00FF, 20);

      // Abort mid-run: reset must take effect without waiting for a clock edge.
      while (!in_ready) @(negedge clk);
      in_valid = 1'b1;
      in_x     = 32'h7FFF_1234;
      in_m     = 16'hFFF1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_in_ready", 64'(in_ready), 64'd1);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_out_r", 64'(out_r), 64'd0);
      check("abort_out_err", 64'(out_err), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_no_result", 64'(out_valid), 64'd0);
      run_op(32'd100, 16'd13, 0);

      for (int t = 0; t < 25; t++) begin
         rx = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: rm = '0;
            1: rm = W'(1);
            2: rm = W'($urandom_range(2, 15));
            default: rm = W'($urandom);
         endcase
         if ($urandom_range(0, 3) == 0) rx = 2*W'(rm) >> $urandom_range(0, 2);
         run_op(rx, rm, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
